freq_counter: RTL and testbench
===============================

Name: freq_counter

Overview:
- Measures the frequency of the square wave from the washer coil pickup while the rover sits over a detected washer.
- Classifies the measurement into a job code and returns it to state_machine, which drives enable_count and consumes done_count and job.
- Gated edge-count design: count rising edges of the synchronised input over a fixed window of CLK cycles, then compare the count against programmable bands.

Parameters:
- GATE_CYCLES, 10_000_000, length of the measurement window in CLK cycles (100 ms at 100 MHz).
- EDGE_W, 16, width of the edge counter; the counter saturates at its maximum value.
- F1_LO, 45, lowest count accepted as the 500 Hz washer (job 1).
- F1_HI, 55, highest count accepted as job 1.
- F2_LO, 90, lowest count accepted as the 1000 Hz washer (job 2).
- F2_HI, 110, highest count accepted as job 2.
- RETRIES, 2, extra windows attempted after an unrecognised result before reporting job 0.

Ports:
- CLK  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable_count  input  1  level request from state_machine; high = measure and hold the result.
- sig_in  input  1  asynchronous square wave from the pickup comparator.
- done_count  output  1  high while a valid result is held.
- job  output  3  result code: 0 = unrecognised, 1 = 500 Hz, 2 = 1000 Hz, 3..7 reserved and never driven.
- busy  output  1  high while in MEASURE or CLASSIFY (drives a debug LED).

Behaviour:
- Input conditioning:
  - sig_in passes through a 2-FF synchroniser, then a registered edge detector.
  - One rise pulse per 0->1 transition of the synchronised signal.
  - Total input latency is 3 CLK cycles.
- Reset (asynchronous): state = IDLE, done_count = 0, job = 0, busy = 0, and all counters and synchroniser flops = 0.
- FSM states: IDLE, MEASURE, CLASSIFY, DONE.
- IDLE:
  - Outputs low and job = 0.
  - When enable_count = 1: clear gate_cnt, edge_cnt and retry_cnt, then go to MEASURE on the next edge.
- MEASURE:
  - gate_cnt increments every cycle.
  - edge_cnt increments on each rise pulse and saturates at 2^EDGE_W - 1.
  - When gate_cnt = GATE_CYCLES-1, go to CLASSIFY. The window is exactly GATE_CYCLES cycles.
  - A rise pulse in that final cycle is counted.
- CLASSIFY (one cycle):
  - F1_LO <= edge_cnt <= F1_HI: job_next = 1.
  - Otherwise, F2_LO <= edge_cnt <= F2_HI: job_next = 2.
  - Otherwise: job_next = 0.
  - Bands are inclusive; if they overlap, band 1 has priority.
  - If job_next = 0 and retry_cnt < RETRIES: increment retry_cnt, clear gate_cnt and edge_cnt, return to MEASURE.
  - Otherwise: register job = job_next and go to DONE.
- DONE:
  - done_count = 1 and job holds its value.
  - The block stays in DONE for as long as enable_count = 1. It never re-measures by itself.
- Drop of enable_count:
  - In any state, enable_count = 0 returns the FSM to IDLE on the next edge, with done_count = 0 and job = 0.
  - A measurement in progress is abandoned without reporting.
- Re-arm: a fresh rising request (enable_count 0 -> 1) is required for a new measurement.
- Timing:
  - Latency from enable_count rise to done_count rise is 1 + N*(GATE_CYCLES+1) cycles, where N = number of windows (1..RETRIES+1).
  - done_count and job change on the same edge.
- Sanity checks on sig_in:
  - sig_in stuck high or low gives a count of 0, so the result is job 0 after all retries.
  - Frequency above the saturation point saturates the counter and the result is job 0 unless a band includes the saturated value.
- Parameter checks: the implementation asserts F1_LO <= F1_HI, F2_LO <= F2_HI and F2_HI < 2^EDGE_W.

Decomposition:
- Shared package (rover_pkg):
  - Job code constants JOB_NONE = 0, JOB_500 = 1, JOB_1000 = 2.
  - FSM state encoding for freq_counter.
  - These are the same constants state_machine decodes.
- Sub-module: sync_edge_detect.
  - Contains the 2-FF synchroniser plus the rising-edge pulse.
  - Reused by the IPS input path.

Test Plan:
- Sim parameters: GATE_CYCLES = 1000, default bands, RETRIES = 2.
1. Job 1 case: sig_in period 20 CLK (50 edges/window); raise enable_count -> done_count rises 1002 cycles later, job = 1, busy low; hold 500 cycles -> outputs stable.
2. Job 2 case: sig_in period 10 CLK (100 edges) -> job = 2 after 1 window; then drop enable_count -> next cycle done_count = 0 and job = 0.
3. Unrecognised: sig_in period 14 CLK (~71 edges) -> 3 windows run (busy high for 3003 cycles), then done_count = 1, job = 0.
4. Retry recovery: sig_in period 14 CLK for the first window, then switched to period 20 -> second window classifies, job = 1 at cycle 2003.
5. Abort: drop enable_count at cycle 400 of MEASURE -> IDLE next cycle, no done_count pulse; re-raise -> a full fresh window, with the count not contaminated by the aborted one.
6. Async reset asserted mid-DONE (job = 2) -> done_count, job and busy = 0 immediately without a clock edge; after release with enable_count still high -> a new measurement starts.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared rover definitions: job codes reported by freq_counter and decoded
// by state_machine, plus the freq_counter FSM state encoding.
package rover_pkg;

  localparam logic [2:0] JOB_NONE = 3'd0;
  localparam logic [2:0] JOB_500  = 3'd1;
  localparam logic [2:0] JOB_1000 = 3'd2;

  typedef enum logic [1:0] {
    FC_IDLE     = 2'd0,
    FC_MEASURE  = 2'd1,
    FC_CLASSIFY = 2'd2,
    FC_DONE     = 2'd3
  } fc_state_t;

  // Maps an edge count onto a job code. Bands are inclusive and the 500 Hz
  // band wins if the two bands overlap.
  function automatic logic [2:0] classify_count(
    input int unsigned count,
    input int unsigned f1_lo,
    input int unsigned f1_hi,
    input int unsigned f2_lo,
    input int unsigned f2_hi
  );
    logic [2:0] code;
    code = JOB_NONE;
    if (count >= f1_lo && count <= f1_hi) begin
      code = JOB_500;
    end else if (count >= f2_lo && count <= f2_hi) begin
      code = JOB_1000;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous input into the CLK domain through two flops and
// emits a one-cycle registered pulse on every rising edge of the
// synchronised signal. Input-to-pulse latency is three CLK cycles.
module sync_edge_detect (
  input  logic CLK,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  // Synchroniser chain, delayed copy and registered rising-edge pulse.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_1   <= sig_in;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      rise     <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/freq_counter.sv
// Gated edge counter for the washer coil pickup. While enable_count is held
// it counts rising edges of sig_in over a fixed window, classifies the count
// into a job code (retrying unrecognised results a few times) and then holds
// the result with done_count until the request is dropped.
module freq_counter
  import rover_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 10_000_000,
  parameter int unsigned EDGE_W      = 16,
  parameter int unsigned F1_LO       = 45,
  parameter int unsigned F1_HI       = 55,
  parameter int unsigned F2_LO       = 90,
  parameter int unsigned F2_HI       = 110,
  parameter int unsigned RETRIES     = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       enable_count,
  input  logic       sig_in,
  output logic       done_count,
  output logic [2:0] job,
  output logic       busy
);

  localparam int unsigned GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned RETRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRIES);
  localparam logic [EDGE_W-1:0]  EDGE_MAX  = '1;
  localparam longint unsigned    EDGE_LIMIT = 64'd1 << EDGE_W;

  fc_state_t          state;
  fc_state_t          state_next;
  logic [GATE_W-1:0]  gate_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         job_next;
  logic               rise;
  logic               start_window;
  logic               clear_retry;
  logic               inc_retry;
  logic               load_job;

  sync_edge_detect u_sync_edge_detect (
    .CLK    (CLK),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Band limits must be ordered and reachable by the edge counter.
  always_ff @(posedge CLK) begin
    assert (F1_LO <= F1_HI);
    assert (F2_LO <= F2_HI);
    assert (64'(F2_HI) < EDGE_LIMIT);
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= FC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, counter controls and status outputs; dropping the
  // request wins over everything and abandons any measurement in progress.
  always_comb begin
    state_next   = state;
    start_window = 1'b0;
    clear_retry  = 1'b0;
    inc_retry    = 1'b0;
    load_job     = 1'b0;
    job_next     = classify_count(32'(edge_cnt), F1_LO, F1_HI, F2_LO, F2_HI);
    done_count   = (state == FC_DONE);
    busy         = (state == FC_MEASURE) || (state == FC_CLASSIFY);
    if (!enable_count) begin
      state_next = FC_IDLE;
    end else begin
      case (state)
        FC_IDLE: begin
          state_next   = FC_MEASURE;
          start_window = 1'b1;
          clear_retry  = 1'b1;
        end
        FC_MEASURE: begin
          if (gate_cnt == GATE_LAST) begin
            state_next = FC_CLASSIFY;
          end
        end
        FC_CLASSIFY: begin
          if (job_next == JOB_NONE && retry_cnt < RETRY_MAX) begin
            state_next   = FC_MEASURE;
            start_window = 1'b1;
            inc_retry    = 1'b1;
          end else begin
            state_next = FC_DONE;
            load_job   = 1'b1;
          end
        end
        FC_DONE: begin
          state_next = FC_DONE;
        end
        default: begin
          state_next = FC_IDLE;
        end
      endcase
    end
  end

  // Window timer and saturating edge counter; both restart at each window.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (start_window) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (state == FC_MEASURE) begin
      gate_cnt <= gate_cnt + 1'b1;
      if (rise && edge_cnt != EDGE_MAX) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // Counts extra windows spent on unrecognised results.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (clear_retry) begin
      retry_cnt <= '0;
    end else if (inc_retry) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Result register: loaded on entry to DONE, cleared when the request drops.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      job <= JOB_NONE;
    end else if (!enable_count) begin
      job <= JOB_NONE;
    end else if (load_job) begin
      job <= job_next;
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench for freq_counter with a 1000-cycle window: a table of
// input frequencies with hand-computed job codes and latencies, followed by
// sequences for hold, request drop, retry recovery, abort and async reset.
module tb_freq_counter;

  localparam int GATE = 1000;
  localparam int ONE_WIN = 1 + 1 * (GATE + 1);
  localparam int TWO_WIN = 1 + 2 * (GATE + 1);
  localparam int THREE_WIN = 1 + 3 * (GATE + 1);
  localparam int LIMIT = 4000;

  typedef struct {
    int         period;
    logic       level;
    logic [2:0] exp_job;
    int         exp_lat;
    int         exp_busy;
  } vector_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic       enable_count;
  logic       sig_in = 1'b0;
  logic       done_count;
  logic [2:0] job;
  logic       busy;

  int   sig_period = 0;
  logic sig_level = 1'b0;
  int   phase = 0;
  int   total_checks = 0;
  int   passed_checks = 0;

  freq_counter #(
    .GATE_CYCLES (GATE),
    .EDGE_W      (16),
    .F1_LO       (45),
    .F1_HI       (55),
    .F2_LO       (90),
    .F2_HI       (110),
    .RETRIES     (2)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .enable_count (enable_count),
    .sig_in       (sig_in),
    .done_count   (done_count),
    .job          (job),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  // Square-wave source with a programmable period in CLK cycles; period 0
  // holds sig_in at a constant level.
  always @(negedge CLK) begin
    if (sig_period == 0) begin
      sig_in = sig_level;
    end else begin
      phase = (phase + 1 >= sig_period) ? 0 : phase + 1;
      sig_in = (phase < sig_period / 2);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int period, input logic level);
    sig_period = period;
    sig_level  = level;
  endtask

  // Drops the request for one edge, lets the new input settle, then raises
  // the request just after a rising edge.
  task automatic start_request();
    @(posedge CLK); #1;
    enable_count = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    enable_count = 1'b1;
  endtask

  // Counts edges until done_count is seen (bounded), and how many of those
  // edges left busy high.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (lat < LIMIT) begin
      @(posedge CLK); #1;
      lat++;
      if (busy) busy_cycles++;
      if (done_count) break;
    end
  endtask

  vector_t vectors[8];

  initial begin
    int lat;
    int busy_cycles;
    int unstable;
    int early_done;

    vectors[0] = '{20, 1'b0, 3'd1, ONE_WIN,   GATE + 1};
    vectors[1] = '{10, 1'b0, 3'd2, ONE_WIN,   GATE + 1};
    vectors[2] = '{14, 1'b0, 3'd0, THREE_WIN, 3 * (GATE + 1)};
    vectors[3] = '{22, 1'b0, 3'd1, ONE_WIN,   GATE + 1};
    vectors[4] = '{11, 1'b0, 3'd2, ONE_WIN,   GATE + 1};
    vectors[5] = '{9,  1'b0, 3'd0, THREE_WIN, 3 * (GATE + 1)};
    vectors[6] = '{0,  1'b0, 3'd0, THREE_WIN, 3 * (GATE + 1)};
    vectors[7] = '{0,  1'b1, 3'd0, THREE_WIN, 3 * (GATE + 1)};

    reset = 1'b1;
    enable_count = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_output("reset_done", int'(done_count), 0);
    check_output("reset_job", int'(job), 0);
    check_output("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Job 1 then hold for 500 cycles with a stable result.
    apply_stimulus(20, 1'b0);
    start_request();
    wait_done(lat, busy_cycles);
    check_output("job1_latency", lat, ONE_WIN);
    check_output("job1_job", int'(job), 1);
    check_output("job1_busy_low", int'(busy), 0);
    unstable = 0;
    repeat (500) begin
      @(posedge CLK); #1;
      if (!done_count || job != 3'd1 || busy) unstable++;
    end
    check_output("job1_hold_unstable_cycles", unstable, 0);

    // Frequency table.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vectors[i].period, vectors[i].level);
      start_request();
      wait_done(lat, busy_cycles);
      check_output($sformatf("vec%0d_latency", i), lat, vectors[i].exp_lat);
      check_output($sformatf("vec%0d_job", i), int'(job), int'(vectors[i].exp_job));
      check_output($sformatf("vec%0d_busy_cycles", i), busy_cycles, vectors[i].exp_busy);
      check_output($sformatf("vec%0d_busy_low", i), int'(busy), 0);
    end

    // Job 2, then dropping the request clears the result on the next edge.
    apply_stimulus(10, 1'b0);
    start_request();
    wait_done(lat, busy_cycles);
    check_output("drop_pre_job", int'(job), 2);
    enable_count = 1'b0;
    @(posedge CLK); #1;
    check_output("drop_done", int'(done_count), 0);
    check_output("drop_job", int'(job), 0);

    // Retry recovery: unrecognised first window, then 500 Hz.
    apply_stimulus(14, 1'b0);
    start_request();
    lat = 0;
    busy_cycles = 0;
    while (lat < LIMIT) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 990) apply_stimulus(20, 1'b0);
      if (busy) busy_cycles++;
      if (done_count) break;
    end
    check_output("retry_latency", lat, TWO_WIN);
    check_output("retry_job", int'(job), 1);
    check_output("retry_busy_cycles", busy_cycles, 2 * (GATE + 1));

    // Abort 400 cycles into a 1000 Hz window, then a fresh 500 Hz window.
    apply_stimulus(10, 1'b0);
    start_request();
    early_done = 0;
    repeat (401) begin
      @(posedge CLK); #1;
      if (done_count) early_done++;
    end
    check_output("abort_busy_before", int'(busy), 1);
    enable_count = 1'b0;
    @(posedge CLK); #1;
    check_output("abort_busy_after", int'(busy), 0);
    check_output("abort_done_after", int'(done_count), 0);
    check_output("abort_no_early_done", early_done, 0);
    apply_stimulus(20, 1'b0);
    enable_count = 1'b1;
    wait_done(lat, busy_cycles);
    check_output("abort_rearm_latency", lat, ONE_WIN);
    check_output("abort_rearm_job", int'(job), 1);

    // Async reset in DONE clears outputs without a clock edge.
    apply_stimulus(10, 1'b0);
    start_request();
    wait_done(lat, busy_cycles);
    check_output("areset_pre_job", int'(job), 2);
    #2;
    reset = 1'b1;
    #1;
    check_output("areset_done", int'(done_count), 0);
    check_output("areset_job", int'(job), 0);
    check_output("areset_busy", int'(busy), 0);
    @(posedge CLK); #1;
    reset = 1'b0;
    wait_done(lat, busy_cycles);
    check_output("areset_restart_latency", lat, ONE_WIN);
    check_output("areset_restart_job", int'(job), 2);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
